down_counter_ckt: RTL and testbench

//  Loadable down-counter, the countdown twin of the lab up-counter.
//  - Loads a small value on start and decrements once per enabled clock.
//  - Pulses done at zero; optionally auto-reloads the last loaded value.
//  - Flags underflow when a decrement is requested at zero.
//  - Sits beside the up-counter in the timing lab and drives delay/tick generation.

---
 rtl/counter_pkg.sv | 8 +
 rtl/down_counter_ckt_if.sv | 26 ++
 rtl/down_counter_ckt.sv | 91 +++++++++
 tb/tb_down_counter_ckt.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and default widths for the lab counters: the up-counter, the
// down-counter and their benches.
package counter_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} cnt_state_t;

  localparam int CNT_IN_WIDTH = 4;
  localparam int CNT_WIDTH    = 8;
endpackage

// File: rtl/down_counter_ckt_if.sv
// Control and status bundle of the loadable down-counter.
// master = the driver of the controls; slave = the counter itself.
interface down_counter_ckt_if #(
  parameter int IN_WIDTH = counter_pkg::CNT_IN_WIDTH,
  parameter int WIDTH    = counter_pkg::CNT_WIDTH
);
  logic                start;
  logic [IN_WIDTH-1:0] number_in;
  logic                count_en;
  logic                pause;
  logic                auto_reload;
  logic [WIDTH-1:0]    Count;
  logic                Done;
  logic                Busy;
  logic                Underflow;

  modport master (
    output start, number_in, count_en, pause, auto_reload,
    input  Count, Done, Busy, Underflow
  );

  modport slave (
    input  start, number_in, count_en, pause, auto_reload,
    output Count, Done, Busy, Underflow
  );
endinterface

// File: rtl/down_counter_ckt.sv
// Loadable down-counter with a one-cycle Done pulse at zero, optional
// auto-reload of the last loaded value, and a sticky Underflow flag.
module down_counter_ckt
  import counter_pkg::*;
#(
  parameter int IN_WIDTH = CNT_IN_WIDTH,
  parameter int WIDTH    = CNT_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  down_counter_ckt_if.slave   bus
);

  cnt_state_t          state_q, state_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [IN_WIDTH-1:0] reload_q, reload_d;
  logic                done_q, done_d;
  logic                unf_q, unf_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      unf_q    <= unf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    unf_d    = unf_q;
    if (bus.start) begin
      count_d  = WIDTH'(bus.number_in);
      reload_d = bus.number_in;
      unf_d    = 1'b0;
      if (bus.number_in == '0) begin
        state_d = DONE;
        // A zero load re-entering DONE must not extend a pulse already high.
        done_d  = !done_q;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        IDLE: ;
        RUN: begin
          if (bus.pause) begin
            state_d = HOLD;
          end else if (bus.count_en) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              count_d = '0;
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        // Release only moves back to RUN; the decrement resumes next cycle.
        HOLD: if (!bus.pause) state_d = RUN;
        DONE: begin
          if (bus.auto_reload && reload_q != '0) begin
            count_d = WIDTH'(reload_q);
            state_d = RUN;
          end else if (bus.count_en) begin
            unf_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.Count     = count_q;
    bus.Done      = done_q;
    bus.Busy      = (state_q == RUN) || (state_q == HOLD);
    bus.Underflow = unf_q;
  end

endmodule

// File: tb/tb_down_counter_ckt.sv
// Directed bench for down_counter_ckt: load, countdown, underflow, auto-reload,
// pause, zero load, reset and reload mid-count.
module tb_down_counter_ckt;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  down_counter_ckt_if bus ();

  down_counter_ckt dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start       = 1'b0;
    bus.number_in   = 4'd0;
    bus.count_en    = 1'b0;
    bus.pause       = 1'b0;
    bus.auto_reload = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (bus.Count !== 8'd0 || bus.Done !== 1'b0 || bus.Busy !== 1'b0 || bus.Underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state Count=%0d Done=%b Busy=%b Unf=%b exp 0/0/0/0",
               bus.Count, bus.Done, bus.Busy, bus.Underflow);
    end
  endtask

  task automatic test_countdown();
    bus.start = 1'b1; bus.number_in = 4'd4; bus.count_en = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.Count !== 8'd4 || bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL cd_load Count=%0d Busy=%b Done=%b exp 4/1/0", bus.Count, bus.Busy, bus.Done);
    end
    for (int i = 3; i >= 0; i--) begin
      step();
      checks++;
      if (bus.Count !== 8'(i) || bus.Done !== (i == 0)) begin
        errors++;
        $display("FAIL cd_step Count=%0d Done=%b exp %0d/%b", bus.Count, bus.Done, i, (i == 0));
      end
    end
    bus.count_en = 1'b0;
    step();
    checks++;
    if (bus.Count !== 8'd0 || bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL cd_after Count=%0d Done=%b Busy=%b exp 0/0/0", bus.Count, bus.Done, bus.Busy);
    end
  endtask

  task automatic test_underflow();
    bus.count_en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (bus.Count !== 8'd0 || bus.Underflow !== 1'b1 || bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL unf_set Count=%0d Unf=%b Done=%b exp 0/1/0", bus.Count, bus.Underflow, bus.Done);
    end
    bus.count_en = 1'b0; bus.start = 1'b1; bus.number_in = 4'd7;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.Count !== 8'd7 || bus.Underflow !== 1'b0) begin
      errors++;
      $display("FAIL unf_clear Count=%0d Unf=%b exp 7/0", bus.Count, bus.Underflow);
    end
  endtask

  task automatic test_auto_reload();
    logic [7:0] exp_cnt;
    bus.start = 1'b1; bus.number_in = 4'd3; bus.auto_reload = 1'b1;
    step();
    bus.start = 1'b0; bus.count_en = 1'b1;
    exp_cnt = 8'd3;
    for (int i = 0; i < 12; i++) begin
      exp_cnt = (exp_cnt == 8'd0) ? 8'd3 : exp_cnt - 8'd1;
      step();
      checks++;
      if (bus.Count !== exp_cnt || bus.Done !== (exp_cnt == 8'd0)) begin
        errors++;
        $display("FAIL ar_cycle%0d Count=%0d Done=%b exp %0d/%b",
                 i, bus.Count, bus.Done, exp_cnt, (exp_cnt == 8'd0));
      end
    end
    bus.auto_reload = 1'b0; bus.count_en = 1'b0;
  endtask

  task automatic test_pause();
    bus.start = 1'b1; bus.number_in = 4'd5;
    step();
    bus.start = 1'b0; bus.count_en = 1'b1;
    step();
    step();
    checks++;
    if (bus.Count !== 8'd3) begin
      errors++;
      $display("FAIL pause_pre Count=%0d exp 3", bus.Count);
    end
    bus.pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.Count !== 8'd3 || bus.Busy !== 1'b1) begin
        errors++;
        $display("FAIL pause_hold Count=%0d Busy=%b exp 3/1", bus.Count, bus.Busy);
      end
    end
    bus.pause = 1'b0;
    step();
    checks++;
    if (bus.Count !== 8'd3) begin
      errors++;
      $display("FAIL pause_release Count=%0d exp 3", bus.Count);
    end
    step();
    checks++;
    if (bus.Count !== 8'd2) begin
      errors++;
      $display("FAIL pause_resume Count=%0d exp 2", bus.Count);
    end
    bus.count_en = 1'b0;
  endtask

  task automatic test_zero_load();
    bus.start = 1'b1; bus.number_in = 4'd0;
    step();
    checks++;
    if (bus.Count !== 8'd0 || bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_load Count=%0d Done=%b Busy=%b exp 0/1/0", bus.Count, bus.Done, bus.Busy);
    end
    step();
    checks++;
    if (bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL zero_held Done=%b exp 0", bus.Done);
    end
    bus.start = 1'b0;
    step();
    checks++;
    if (bus.Done !== 1'b0 || bus.Count !== 8'd0) begin
      errors++;
      $display("FAIL zero_after Done=%b Count=%0d exp 0/0", bus.Done, bus.Count);
    end
  endtask

  task automatic test_reset_and_restart();
    bus.start = 1'b1; bus.number_in = 4'd5;
    step();
    bus.start = 1'b0; bus.count_en = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; bus.count_en = 1'b0;
    checks++;
    if (bus.Count !== 8'd0 || bus.Done !== 1'b0 || bus.Busy !== 1'b0 || bus.Underflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset Count=%0d Done=%b Busy=%b Unf=%b exp 0/0/0/0",
               bus.Count, bus.Done, bus.Busy, bus.Underflow);
    end
    bus.start = 1'b1; bus.number_in = 4'd5;
    step();
    bus.start = 1'b0; bus.count_en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (bus.Count !== 8'd2) begin
      errors++;
      $display("FAIL restart_pre Count=%0d exp 2", bus.Count);
    end
    bus.start = 1'b1; bus.number_in = 4'd9;
    step();
    checks++;
    if (bus.Count !== 8'd9 || bus.Underflow !== 1'b0 || bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_9 Count=%0d Unf=%b Busy=%b exp 9/0/1", bus.Count, bus.Underflow, bus.Busy);
    end
    step();
    checks++;
    if (bus.Count !== 8'd9) begin
      errors++;
      $display("FAIL start_held Count=%0d exp 9", bus.Count);
    end
    bus.start = 1'b0;
    step();
    checks++;
    if (bus.Count !== 8'd8) begin
      errors++;
      $display("FAIL start_release Count=%0d exp 8", bus.Count);
    end
    bus.count_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_underflow();
    test_auto_reload();
    test_pause();
    test_zero_load();
    test_reset_and_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
